// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_unit
//  Purpose  : Iterative signed 32-bit multiply / divide coprocessor for the
//             execute stage. Multiply is radix-2 Booth, one bit per cycle.
//             Divide is restoring division on magnitudes, one quotient bit per
//             cycle. Latency is fixed at 33 cycles for every operation.
//  Ports    : clock          - rising-edge master clock
//             reset          - asynchronous, active-low
//             data_operandA  - multiplicand / dividend (two's complement)
//             data_operandB  - multiplier / divisor (two's complement)
//             ctrl_MULT      - start-multiply pulse (wins over ctrl_DIV)
//             ctrl_DIV       - start-divide pulse
//             data_result    - low 32 bits of product / quotient (registered)
//             data_exception - overflow or divide-by-zero, valid with RDY
//             data_resultRDY - one-cycle completion pulse (registered)
//             busy           - operation in flight
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count;

    // Shared datapath:
    //   MULT: hi = upper accumulator (one guard bit), lo = multiplier, qm1 = Booth bit
    //   DIV : hi = partial remainder, lo = dividend shifting out / quotient shifting in
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic             qm1;
    logic [WIDTH:0]   opb;        // sign-extended multiplicand or divisor magnitude
    logic             quot_neg;
    logic             div_zero;
    logic             div_ovf;

    logic             start_mult;
    logic             start_div;
    logic             iterating;
    logic             finishing;

    assign start_mult = ctrl_MULT;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;
    assign iterating  = (state_q == S_MULT) || (state_q == S_DIV);
    assign finishing  = iterating && (count == LAST_CNT);
    assign busy       = iterating;

    // Operand magnitudes. A 32-bit magnitude of 0x80000000 is 0x80000000 read
    // as unsigned, so the dividend fits in lo; the divisor gets a zero guard bit.
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH:0]   mag_b;
    assign mag_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign mag_b = {1'b0, data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB};

    // Booth step
    logic [WIDTH:0] booth_sum;
    always_comb begin
        booth_sum = hi;
        case ({lo[0], qm1})
            2'b01:   booth_sum = hi + opb;
            2'b10:   booth_sum = hi - opb;
            default: booth_sum = hi;
        endcase
    end

    // Restoring division step; diff[WIDTH+1] set means trial subtraction failed
    logic [WIDTH:0]   div_trial;
    logic [WIDTH+1:0] div_diff;
    assign div_trial = {hi[WIDTH-1:0], lo[WIDTH-1]};
    assign div_diff  = {1'b0, div_trial} - {1'b0, opb};

    // Final result selection
    logic [WIDTH:0]   prod_top;   // product bits 63..31
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;
    always_comb begin
        prod_top   = {hi[WIDTH-1:0], lo[WIDTH-1]};
        fin_result = '0;
        fin_exc    = 1'b0;
        if (state_q == S_MULT) begin
            fin_result = lo;
            fin_exc    = ~((&prod_top) | ~(|prod_top));
        end else if (div_zero) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else begin
            fin_result = quot_neg ? (~lo + 1'b1) : lo;
            fin_exc    = div_ovf;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any start restarts, aborting whatever was in flight
    always_comb begin
        state_d = state_q;
        if (start_mult) begin
            state_d = S_MULT;
        end else if (start_div) begin
            state_d = S_DIV;
        end else begin
            case (state_q)
                S_MULT, S_DIV: if (count == LAST_CNT) state_d = S_DONE;
                S_DONE:        state_d = S_IDLE;
                default:       state_d = state_q;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count          <= '0;
            hi             <= '0;
            lo             <= '0;
            qm1            <= 1'b0;
            opb            <= '0;
            quot_neg       <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start_mult) begin
                count    <= '0;
                hi       <= '0;
                lo       <= data_operandB;
                qm1      <= 1'b0;
                opb      <= {data_operandA[WIDTH-1], data_operandA};
                quot_neg <= 1'b0;
                div_zero <= 1'b0;
                div_ovf  <= 1'b0;
            end else if (start_div) begin
                count    <= '0;
                hi       <= '0;
                lo       <= mag_a;
                qm1      <= 1'b0;
                opb      <= mag_b;
                quot_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                            (data_operandB == '1);
            end else if (finishing) begin
                data_result    <= fin_result;
                data_exception <= fin_exc;
                data_resultRDY <= 1'b1;
            end else if (state_q == S_MULT) begin
                hi    <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                lo    <= {booth_sum[0], lo[WIDTH-1:1]};
                qm1   <= lo[0];
                count <= count + 1'b1;
            end else if (state_q == S_DIV) begin
                if (!div_diff[WIDTH+1]) begin
                    hi <= div_diff[WIDTH:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= div_trial;
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
                count <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_unit
//  Purpose  : Directed self-checking bench for multdiv_unit with
//             hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        do_mult;
    logic        do_div;
    logic [31:0] result;
    logic        exc;
    logic        rdy;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clk),
        .reset          (rst_n),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .ctrl_MULT      (do_mult),
        .ctrl_DIV       (do_div),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the next rising edge is E0. Returns at the
    // falling edge right after E0.
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        do_mult = m;
        do_div  = d;
        op_a    = a;
        op_b    = b;
        @(negedge clk);
        do_mult = 1'b0;
        do_div  = 1'b0;
    endtask

    // Watches 40 cycles after E0; RDY must pulse once, right after E0+33.
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_exc);
        int   first  = 0;
        int   pulses = 0;
        logic busy_pre = 1'b0;
        logic busy_at  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 32) busy_pre = busy;
            if (k == 33) busy_at  = busy;
        end
        check({tag, " latency"},   32'(first),    32'd33);
        check({tag, " rdy_count"}, 32'(pulses),   32'd1);
        check({tag, " busy_pre"},  {31'd0, busy_pre}, 32'd1);
        check({tag, " busy_done"}, {31'd0, busy_at},  32'd0);
        check({tag, " result"},    result,        exp_res);
        check({tag, " exc"},       {31'd0, exc},  {31'd0, exp_exc});
    endtask

    initial begin
        int pulses;
        rst_n   = 1'b0;
        op_a    = '0;
        op_b    = '0;
        do_mult = 1'b0;
        do_div  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset exc",    {31'd0, exc},  32'd0);
        check("reset rdy",    {31'd0, rdy},  32'd0);
        check("reset busy",   {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        check("mul busy", {31'd0, busy}, 32'd1);
        wait_done("mul 7x-3", 32'hFFFF_FFEB, 1'b0);
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_done("mul 2^16x2^16", 32'h0000_0000, 1'b1);
        start(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        wait_done("mul min x1", 32'h8000_0000, 1'b0);
        start(1'b1, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFF9);
        wait_done("mul -6x-7", 32'd42, 1'b0);
        start(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
        wait_done("mul max x2", 32'hFFFF_FFFE, 1'b1);
        start(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mul min x min", 32'h0000_0000, 1'b1);

        // Divide
        start(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done("div -100/7", 32'hFFFF_FFF2, 1'b0);
        start(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done("div 100/-7", 32'hFFFF_FFF2, 1'b0);
        start(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done("div 5/0", 32'h0000_0000, 1'b1);
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div min/-1", 32'h8000_0000, 1'b1);
        start(1'b0, 1'b1, 32'd3, 32'd5);
        wait_done("div 3/5", 32'd0, 1'b0);
        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("div -7/2", 32'hFFFF_FFFD, 1'b0);
        start(1'b0, 1'b1, 32'h8000_0000, 32'd2);
        wait_done("div min/2", 32'hC000_0000, 1'b0);

        // Abort: multiply restarted by a divide sampled at E0+10
        start(1'b1, 1'b0, 32'd3, 32'd4);
        pulses = 0;
        repeat (9) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        start(1'b0, 1'b1, 32'd20, 32'd4);
        check("abort early rdy", 32'(pulses), 32'd0);
        wait_done("abort div 20/4", 32'd5, 1'b0);

        // Both starts together: multiply wins
        start(1'b1, 1'b1, 32'd6, 32'd2);
        wait_done("both 6,2", 32'd12, 1'b0);

        // Leave exception set so the reset check below has something to clear
        start(1'b0, 1'b1, 32'd9, 32'd0);
        wait_done("div 9/0", 32'd0, 1'b1);

        // Asynchronous reset mid-operation
        start(1'b1, 1'b0, 32'd11, 32'd13);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst result", result, 32'd0);
        check("async rst exc",    {31'd0, exc},  32'd0);
        check("async rst busy",   {31'd0, busy}, 32'd0);
        check("async rst rdy",    {31'd0, rdy},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy || busy) pulses++;
        end
        check("post rst idle", 32'(pulses), 32'd0);
        start(1'b1, 1'b0, 32'd11, 32'd13);
        wait_done("post rst mul", 32'd143, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
